// File: rtl/dm_sb_arbiter.sv
// Round-robin arbiter sharing one req/gnt/r_valid system-bus master port between NumReq requesters.
// Define DM_SB_ARB_TIMEOUT_EN to add the response timeout (r_err_o); otherwise WaitResp waits indefinitely.
module dm_sb_arbiter #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                dmactive_i,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0][BusWidth-1:0]     add_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][BusWidth-1:0]     wdata_i,
    input  logic [NumReq-1:0][BusWidth/8-1:0]   be_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   r_valid_o,
    output logic [BusWidth-1:0]                 r_rdata_o,
    output logic                                r_err_o,
    output logic                                master_req_o,
    output logic [BusWidth-1:0]                 master_add_o,
    output logic                                master_we_o,
    output logic [BusWidth-1:0]                 master_wdata_o,
    output logic [BusWidth/8-1:0]               master_be_o,
    input  logic                                master_gnt_i,
    input  logic                                master_r_valid_i,
    input  logic [BusWidth-1:0]                 master_r_rdata_i
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {
        Idle,
        WaitResp
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] prio_q, prio_d;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] owner_next;
    logic [IdxW:0]   cand;
    logic            any_req;
    logic            tmo_hit;
    logic            resp_done;

    assign r_rdata_o = master_r_rdata_i;

    // Scan from prio_q upwards; wrap by explicit compare so non-power-of-2 NumReq works.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, prio_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NumReq)) begin
                cand = cand - (IdxW+1)'(NumReq);
            end
            if (!any_req && req_i[cand[IdxW-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[IdxW-1:0];
            end
        end
    end

    assign owner_next = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

`ifdef DM_SB_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    logic [TmoW-1:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q == WaitResp) && !master_r_valid_i &&
                     (tmo_q == TmoW'(TimeoutCycles - 1));

    // Held at zero in Idle, so the count always starts fresh on entry to WaitResp.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == Idle) begin
            tmo_d = '0;
        end else if (!tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign resp_done = (state_q == WaitResp) && (master_r_valid_i || tmo_hit);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        prio_d         = prio_q;
        master_req_o   = 1'b0;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        gnt_o          = '0;
        r_valid_o      = '0;
        r_err_o        = 1'b0;

        case (state_q)
            Idle: begin
                if (any_req && dmactive_i) begin
                    master_req_o   = 1'b1;
                    master_add_o   = add_i[winner];
                    master_we_o    = we_i[winner];
                    master_wdata_o = wdata_i[winner];
                    master_be_o    = be_i[winner];
                    gnt_o[winner]  = master_gnt_i;
                    if (master_gnt_i) begin
                        owner_d = winner;
                        state_d = WaitResp;
                    end
                end
            end
            WaitResp: begin
                // The response is always drained, even after dmactive drops, to avoid an orphan on the bus.
                if (resp_done) begin
                    state_d = Idle;
                    prio_d  = owner_next;
                    if (dmactive_i) begin
                        r_valid_o[owner_q] = 1'b1;
                        r_err_o            = tmo_hit;
                    end
                end
            end
            default: state_d = Idle;
        endcase

        if (!dmactive_i) begin
            prio_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            owner_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_dm_sb_arbiter.sv
// Directed bench for dm_sb_arbiter (NumReq=2); with DM_SB_ARB_TIMEOUT_EN it uses TimeoutCycles=8.
module tb_dm_sb_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned NR = 2;
`ifdef DM_SB_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        dmactive;
    logic [NR-1:0]               req;
    logic [NR-1:0][BW-1:0]       add;
    logic [NR-1:0]               we;
    logic [NR-1:0][BW-1:0]       wdata;
    logic [NR-1:0][BW/8-1:0]     be;
    logic [NR-1:0]               gnt;
    logic [NR-1:0]               r_valid;
    logic [BW-1:0]               r_rdata;
    logic                        r_err;
    logic                        m_req;
    logic [BW-1:0]               m_add;
    logic                        m_we;
    logic [BW-1:0]               m_wdata;
    logic [BW/8-1:0]             m_be;
    logic                        m_gnt;
    logic                        m_r_valid;
    logic [BW-1:0]               m_r_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_sb_arbiter #(
        .BusWidth      (BW),
        .NumReq        (NR),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .dmactive_i       (dmactive),
        .req_i            (req),
        .add_i            (add),
        .we_i             (we),
        .wdata_i          (wdata),
        .be_i             (be),
        .gnt_o            (gnt),
        .r_valid_o        (r_valid),
        .r_rdata_o        (r_rdata),
        .r_err_o          (r_err),
        .master_req_o     (m_req),
        .master_add_o     (m_add),
        .master_we_o      (m_we),
        .master_wdata_o   (m_wdata),
        .master_be_o      (m_be),
        .master_gnt_i     (m_gnt),
        .master_r_valid_i (m_r_valid),
        .master_r_rdata_i (m_r_rdata)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmactive = 1'b1; req = '0; add = '0; we = '0; wdata = '0; be = '0;
        m_gnt = 1'b0; m_r_valid = 1'b0; m_r_rdata = 32'h12345678;
        #12;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_master_req: got %b expected 0", m_req); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL reset_r_valid: got %b expected 00", r_valid); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL reset_r_err: got %b expected 0", r_err); end
        checks++; if (m_add !== 32'h0) begin errors++; $display("FAIL reset_master_add: got %h expected 0", m_add); end
        checks++; if (r_rdata !== 32'h12345678) begin errors++; $display("FAIL reset_rdata_follow: got %h expected 12345678", r_rdata); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req = 2'b01; add[0] = 32'h1000; we[0] = 1'b0; m_gnt = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL single_master_req: got %b expected 1", m_req); end
        checks++; if (m_add !== 32'h1000) begin errors++; $display("FAIL single_master_add: got %h expected 1000", m_add); end
        checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL single_master_we: got %b expected 0", m_we); end
        tick();
        req = 2'b00; m_gnt = 1'b0;
        #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL single_wait_req: got %b expected 0", m_req); end
        checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL single_wait_rvalid: got %b expected 00", r_valid); end
        tick();
        m_r_valid = 1'b1; m_r_rdata = 32'hCAFE0001;
        #1;
        checks++; if (r_valid !== 2'b01) begin errors++; $display("FAIL single_rvalid: got %b expected 01", r_valid); end
        checks++; if (r_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL single_rdata: got %h expected cafe0001", r_rdata); end
        tick();
        m_r_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        int unsigned exp_w;
        exp_w = 1;
        add[0] = 32'hA0; add[1] = 32'hB0;
        for (int n = 0; n < 4; n++) begin
            req = 2'b11; m_gnt = 1'b1;
            #1;
            checks++; if (gnt !== (2'b01 << exp_w)) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", n, gnt, 2'b01 << exp_w); end
            checks++; if (m_add !== ((exp_w == 1) ? 32'hB0 : 32'hA0)) begin errors++; $display("FAIL rr_add%0d: got %h expected %h", n, m_add, (exp_w == 1) ? 32'hB0 : 32'hA0); end
            tick();
            m_gnt = 1'b0; m_r_valid = 1'b1;
            #1;
            checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_stall%0d: got %b expected 00", n, gnt); end
            checks++; if (r_valid !== (2'b01 << exp_w)) begin errors++; $display("FAIL rr_rvalid%0d: got %b expected %b", n, r_valid, 2'b01 << exp_w); end
            tick();
            m_r_valid = 1'b0;
            exp_w = 1 - exp_w;
        end
        req = 2'b00;
    endtask

    task automatic test_gnt_stall();
        req = 2'b10; add[1] = 32'h2000; we[1] = 1'b1; wdata[1] = 32'h55AA; be[1] = 4'hC; m_gnt = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req = 2'b11;
            #1;
            checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL stall_req%0d: got %b expected 1", c, m_req); end
            checks++; if (m_add !== 32'h2000) begin errors++; $display("FAIL stall_add%0d: got %h expected 2000", c, m_add); end
            checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL stall_we%0d: got %b expected 1", c, m_we); end
            checks++; if (m_wdata !== 32'h55AA) begin errors++; $display("FAIL stall_wdata%0d: got %h expected 55aa", c, m_wdata); end
            checks++; if (m_be !== 4'hC) begin errors++; $display("FAIL stall_be%0d: got %h expected c", c, m_be); end
            checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL stall_gnt%0d: got %b expected 00", c, gnt); end
            tick();
        end
        m_gnt = 1'b1;
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL stall_final_gnt: got %b expected 10", gnt); end
        tick();
        m_gnt = 1'b0; req = 2'b00; m_r_valid = 1'b1;
        tick();
        m_r_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        req = 2'b01; m_gnt = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_gnt0: got %b expected 01", gnt); end
        tick();
        m_gnt = 1'b1; req = 2'b11; m_r_valid = 1'b1;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL b2b_no_gnt: got %b expected 00", gnt); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL b2b_no_req: got %b expected 0", m_req); end
        checks++; if (r_valid !== 2'b01) begin errors++; $display("FAIL b2b_rvalid: got %b expected 01", r_valid); end
        tick();
        m_r_valid = 1'b0;
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_next_gnt: got %b expected 10", gnt); end
        tick();
        m_gnt = 1'b0; req = 2'b00; m_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 2'b10) begin errors++; $display("FAIL b2b_rvalid1: got %b expected 10", r_valid); end
        tick();
        m_r_valid = 1'b0;
    endtask

    task automatic test_stray();
        req = 2'b00; m_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL stray_rvalid: got %b expected 00", r_valid); end
        tick();
        m_r_valid = 1'b0;
    endtask

    task automatic test_dmactive();
        req = 2'b01; m_gnt = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL dma_gnt: got %b expected 01", gnt); end
        tick();
        m_gnt = 1'b0; req = 2'b00; dmactive = 1'b0;
        tick();
        m_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL dma_suppress: got %b expected 00", r_valid); end
        tick();
        m_r_valid = 1'b0; req = 2'b11; m_gnt = 1'b1;
        #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL dma_req_forced: got %b expected 0", m_req); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL dma_gnt_forced: got %b expected 00", gnt); end
        tick();
        dmactive = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL dma_prio_cleared: got %b expected 01", gnt); end
        tick();
        m_gnt = 1'b0; req = 2'b00; m_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 2'b01) begin errors++; $display("FAIL dma_resume_rvalid: got %b expected 01", r_valid); end
        tick();
        m_r_valid = 1'b0;
    endtask

`ifdef DM_SB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req = 2'b01; m_gnt = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL tmo_gnt: got %b expected 01", gnt); end
        tick();
        req = 2'b00; m_gnt = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checks++; if (r_valid !== ((k == 8) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL tmo_rvalid_c%0d: got %b expected %b", k, r_valid, (k == 8) ? 2'b01 : 2'b00); end
            checks++; if (r_err !== (k == 8)) begin errors++; $display("FAIL tmo_err_c%0d: got %b expected %b", k, r_err, k == 8); end
            tick();
        end
        m_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL tmo_late_rvalid: got %b expected 00", r_valid); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL tmo_late_err: got %b expected 0", r_err); end
        tick();
        m_r_valid = 1'b0; req = 2'b01; m_gnt = 1'b1;
        tick();
        req = 2'b00; m_gnt = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b expected 0", m_req); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL arst_gnt: got %b expected 00", gnt); end
        checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL arst_rvalid: got %b expected 00", r_valid); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL arst_err: got %b expected 0", r_err); end
        #2 rst_n = 1'b1;
        req = 2'b01; m_r_valid = 1'b1;
        #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL arst_idle_req: got %b expected 1", m_req); end
        checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL arst_idle_rvalid: got %b expected 00", r_valid); end
        tick();
        req = 2'b00; m_r_valid = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        req = 2'b01; m_gnt = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL notmo_gnt: got %b expected 01", gnt); end
        tick();
        req = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            #1;
            checks++; if (r_valid !== 2'b00) begin errors++; $display("FAIL notmo_rvalid_c%0d: got %b expected 00", k, r_valid); end
            checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL notmo_err_c%0d: got %b expected 0", k, r_err); end
            checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL notmo_gnt_c%0d: got %b expected 00", k, gnt); end
            tick();
        end
        req = 2'b00; m_gnt = 1'b0; m_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 2'b01) begin errors++; $display("FAIL notmo_final_rvalid: got %b expected 01", r_valid); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL notmo_final_err: got %b expected 0", r_err); end
        tick();
        m_r_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gnt_stall();
        test_back_to_back();
        test_stray();
        test_dmactive();
`ifdef DM_SB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
